// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared constants, state encoding and reset wait-state values for the bus arbiter
package bus_pkg;

  localparam int NMASTER_DEF = 3;
  localparam int DELAYW_DEF  = 4;

  // Master indices (bit positions in req/grant/master_wait)
  localparam int M_CPU = 0;
  localparam int M_VGA = 1;
  localparam int M_DMA = 2;

  // Chip-select codes returned by the external address decoder; 0 means unmapped
  localparam logic [3:0] CS_NONE    = 4'd0;
  localparam logic [3:0] CS_VECTORS = 4'd1;
  localparam logic [3:0] CS_ROM     = 4'd2;
  localparam logic [3:0] CS_RAM     = 4'd3;
  localparam logic [3:0] CS_IO      = 4'd4;
  localparam logic [3:0] CS_LED     = 4'd5;
  localparam logic [3:0] CS_SSRAM   = 4'd6;

  // Wait states loaded into the table at reset; every other entry is zero
  localparam int RST_DELAY_LED   = 1;
  localparam int RST_DELAY_SSRAM = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Reset value of one wait-state table entry
  function automatic int rst_delay(input logic [3:0] idx);
    case (idx)
      CS_LED:   return RST_DELAY_LED;
      CS_SSRAM: return RST_DELAY_SSRAM;
      default:  return 0;
    endcase
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotate-priority encoder choosing the next requester after the last one served
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  winner_o,
  output logic          valid_o
);

  // Scan from last+1 upward with wrap-around; the first set request wins
  always_comb begin
    int          raw;
    logic [IW-1:0] idx;
    winner_o = '0;
    valid_o  = 1'b0;
    raw      = 0;
    idx      = '0;
    for (int k = 1; k <= N; k++) begin
      raw = int'(last_i) + k;
      if (raw >= N) raw = raw - N;
      idx = IW'(raw);
      if (!valid_o && req_i[idx]) begin
        winner_o[idx] = 1'b1;
        valid_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// rtl/bus_arbiter_rr.sv - round-robin bus arbiter with per-chip-select wait-state sequencing
module bus_arbiter_rr
  import bus_pkg::*;
#(
  parameter int NMASTER = NMASTER_DEF,
  parameter int DELAYW  = DELAYW_DEF
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NMASTER-1:0] req,
  input  logic [3:0]         cs,
  input  logic               cfg_we,
  input  logic [3:0]         cfg_cs,
  input  logic [DELAYW-1:0]  cfg_delay,
  output logic [NMASTER-1:0] grant,
  output logic               start,
  output logic               chipselect_en,
  output logic [NMASTER-1:0] master_wait,
  output logic               bus_error
);

  localparam int LW = (NMASTER > 1) ? $clog2(NMASTER) : 1;

  state_e             state_q, state_d;
  logic [NMASTER-1:0] grant_q, grant_d;
  logic [LW-1:0]      last_q, last_d;
  logic [DELAYW-1:0]  cnt_q, cnt_d;
  logic [3:0]         cs_q, cs_d;
  logic [DELAYW-1:0]  table_q [16];

  logic [NMASTER-1:0] pick_winner;
  logic               pick_valid;
  logic [LW-1:0]      gidx;
  logic               req_g;
  logic [DELAYW-1:0]  cur_delay;

  rr_pick #(
    .N  (NMASTER),
    .IW (LW)
  ) u_pick (
    .req_i    (req),
    .last_i   (last_q),
    .winner_o (pick_winner),
    .valid_o  (pick_valid)
  );

  // Index of the currently granted master, used to update the round-robin pointer
  always_comb begin
    gidx = '0;
    for (int i = 0; i < NMASTER; i++) begin
      if (grant_q[i]) gidx = LW'(i);
    end
  end

  assign req_g     = |(req & grant_q);
  assign cur_delay = table_q[cs];

  // Next-state logic: grant, latch cs and count down wait states; any req drop ends the access
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    cs_d    = cs_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_winner;
          state_d = ST_START;
        end
      end
      ST_START: begin
        cs_d  = cs;
        cnt_d = cur_delay;
        if (!req_g) begin
          grant_d = '0;
          last_d  = gidx;
          state_d = ST_IDLE;
        end else if (cur_delay == '0 || cs == CS_NONE) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!req_g) begin
          grant_d = '0;
          cnt_d   = '0;
          last_d  = gidx;
          state_d = ST_IDLE;
        end else if (cnt_q == DELAYW'(1)) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - DELAYW'(1);
        end
      end
      ST_DONE: begin
        if (!req_g) begin
          grant_d = '0;
          last_d  = gidx;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer registers; last starts at the top master so the CPU wins first
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= LW'(NMASTER - 1);
      cnt_q   <= '0;
      cs_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      cs_q    <= cs_d;
    end
  end

  // Wait-state table as flops so a write is visible to a read on the very next cycle
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) begin
        table_q[i] <= DELAYW'(rst_delay(4'(i)));
      end
    end else if (cfg_we) begin
      table_q[cfg_cs] <= cfg_delay;
    end
  end

  assign grant         = grant_q;
  assign start         = (state_q == ST_START);
  assign chipselect_en = (state_q != ST_IDLE);
  assign master_wait   = (state_q == ST_DONE) ? ~grant_q : '1;
  assign bus_error     = (state_q == ST_DONE) && (cs_q == CS_NONE);

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb/tb_bus_arbiter_rr.sv - directed scoreboard bench for bus_arbiter_rr
module tb_bus_arbiter_rr;
  import bus_pkg::*;

  logic       clock;
  logic       reset_n;
  logic [2:0] req;
  logic [3:0] cs;
  logic       cfg_we;
  logic [3:0] cfg_cs;
  logic [3:0] cfg_delay;
  logic [2:0] grant;
  logic       start;
  logic       chipselect_en;
  logic [2:0] master_wait;
  logic       bus_error;

  bus_arbiter_rr #(.NMASTER(3), .DELAYW(4)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .req           (req),
    .cs            (cs),
    .cfg_we        (cfg_we),
    .cfg_cs        (cfg_cs),
    .cfg_delay     (cfg_delay),
    .grant         (grant),
    .start         (start),
    .chipselect_en (chipselect_en),
    .master_wait   (master_wait),
    .bus_error     (bus_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      tag;
    logic [2:0] g;
    logic       st;
    logic       ce;
    logic [2:0] mw;
    logic       be;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input string what, input logic [2:0] obs, input logic [2:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s.%s observed=%b expected=%b", tag, what, obs, expv);
    end
  endtask

  // Push what the outputs must look like after the next edge, then take that edge and compare
  task automatic step(input string tag, input logic [2:0] g, input logic st, input logic ce,
                      input logic [2:0] mw, input logic be);
    exp_t e;
    e.tag = tag; e.g = g; e.st = st; e.ce = ce; e.mw = mw; e.be = be;
    sb.push_back(e);
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk(e.tag, "grant",         grant,                 e.g);
      chk(e.tag, "start",         {2'b00, start},        {2'b00, e.st});
      chk(e.tag, "chipselect_en", {2'b00, chipselect_en}, {2'b00, e.ce});
      chk(e.tag, "master_wait",   master_wait,           e.mw);
      chk(e.tag, "bus_error",     {2'b00, bus_error},    {2'b00, e.be});
    end
  endtask

  task automatic idle(input string tag);
    step(tag, 3'b000, 1'b0, 1'b0, 3'b111, 1'b0);
  endtask

  initial begin
    clock     = 1'b0;
    reset_n   = 1'b0;
    req       = 3'b000;
    cs        = CS_NONE;
    cfg_we    = 1'b0;
    cfg_cs    = 4'd0;
    cfg_delay = 4'd0;

    // Reset state
    idle("rst0");
    idle("rst1");
    reset_n = 1'b1;
    idle("rst_rel");

    // Round robin: all request, zero-wait chip select, each drops for one cycle in DONE
    req = 3'b111; cs = CS_IO;
    step("rr_cpu_start", 3'b001, 1, 1, 3'b111, 0);
    step("rr_cpu_done",  3'b001, 0, 1, 3'b110, 0);
    req = 3'b110;
    idle("rr_cpu_idle");
    req = 3'b111;
    step("rr_vga_start", 3'b010, 1, 1, 3'b111, 0);
    step("rr_vga_done",  3'b010, 0, 1, 3'b101, 0);
    req = 3'b101;
    idle("rr_vga_idle");
    req = 3'b111;
    step("rr_dma_start", 3'b100, 1, 1, 3'b111, 0);
    step("rr_dma_done",  3'b100, 0, 1, 3'b011, 0);
    req = 3'b011;
    idle("rr_dma_idle");
    req = 3'b111;
    step("rr_cpu2_start", 3'b001, 1, 1, 3'b111, 0);
    step("rr_cpu2_done",  3'b001, 0, 1, 3'b110, 0);
    req = 3'b110;
    idle("rr_cpu2_idle");
    req = 3'b000;
    idle("rr_end");

    // CPU access to SSRAM (two wait states), held in DONE until req drops
    req = 3'b001; cs = CS_SSRAM;
    step("ssram_c1", 3'b001, 1, 1, 3'b111, 0);
    step("ssram_c2", 3'b001, 0, 1, 3'b111, 0);
    step("ssram_c3", 3'b001, 0, 1, 3'b111, 0);
    step("ssram_c4", 3'b001, 0, 1, 3'b110, 0);
    step("ssram_c5", 3'b001, 0, 1, 3'b110, 0);
    req = 3'b000;
    idle("ssram_drop");

    // Program entry 3 to 5 waits; VGA access, with a rewrite of entry 3 during START
    cfg_we = 1'b1; cfg_cs = CS_RAM; cfg_delay = 4'd5;
    idle("cfg_wr");
    cfg_we = 1'b0;
    req = 3'b010; cs = CS_RAM;
    step("ram_c1", 3'b010, 1, 1, 3'b111, 0);
    cfg_we = 1'b1; cfg_delay = 4'd1;
    step("ram_c2", 3'b010, 0, 1, 3'b111, 0);
    cfg_we = 1'b0;
    step("ram_c3", 3'b010, 0, 1, 3'b111, 0);
    step("ram_c4", 3'b010, 0, 1, 3'b111, 0);
    step("ram_c5", 3'b010, 0, 1, 3'b111, 0);
    step("ram_c6", 3'b010, 0, 1, 3'b111, 0);
    step("ram_c7", 3'b010, 0, 1, 3'b101, 0);
    req = 3'b000;
    idle("ram_drop");

    // DMA to unmapped address: DONE right after START with bus_error
    req = 3'b100; cs = CS_NONE;
    step("unm_c1", 3'b100, 1, 1, 3'b111, 0);
    step("unm_c2", 3'b100, 0, 1, 3'b011, 1);
    step("unm_c3", 3'b100, 0, 1, 3'b011, 1);
    req = 3'b000;
    idle("unm_drop");

    // CPU aborts during WAIT, then a VGA-only request is served (entry 3 now 1)
    req = 3'b001; cs = CS_SSRAM;
    step("abt_c1", 3'b001, 1, 1, 3'b111, 0);
    step("abt_c2", 3'b001, 0, 1, 3'b111, 0);
    req = 3'b000;
    idle("abt_idle");
    req = 3'b010; cs = CS_RAM;
    step("abt_vga_start", 3'b010, 1, 1, 3'b111, 0);
    step("abt_vga_wait",  3'b010, 0, 1, 3'b111, 0);
    step("abt_vga_done",  3'b010, 0, 1, 3'b101, 0);
    req = 3'b000;
    idle("abt_vga_drop");

    // Reset asserted during WAIT clears everything including the table
    req = 3'b001; cs = CS_SSRAM;
    step("mrst_c1", 3'b001, 1, 1, 3'b111, 0);
    step("mrst_c2", 3'b001, 0, 1, 3'b111, 0);
    reset_n = 1'b0;
    idle("mrst_assert");
    reset_n = 1'b1; req = 3'b000;
    idle("mrst_release");
    req = 3'b010; cs = CS_RAM;
    step("tbl_rst_start", 3'b010, 1, 1, 3'b111, 0);
    step("tbl_rst_done",  3'b010, 0, 1, 3'b101, 0);
    req = 3'b000;
    idle("tbl_rst_drop");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_rr.md
# bus_arbiter_rr

Round-robin bus arbiter and wait-state sequencer for the shared system bus. It grants one of NMASTER requesters (CPU, VGA, DMA) at a time and holds the grant until that master drops its request. It inserts a per-chip-select programmable number of wait states before releasing the master's wait. It sits between the masters and the external address decoder; the decoder returns the 4-bit chip select of the granted master's address, and this block sequences the access against it.

## Interface
- NMASTER, 3, number of requesters; bit 0 = CPU, 1 = VGA, 2 = DMA
- DELAYW, 4, width of a wait-state count
- clock  in  1  system clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- req  in  NMASTER  per-master request (read or write), level, held until access completes
- cs  in  4  chip select decoded from the granted master's address; 0 = unmapped
- cfg_we  in  1  write one wait-state table entry
- cfg_cs  in  4  table index to write
- cfg_delay  in  DELAYW  wait-state count to store
- grant  out  NMASTER  one-hot grant, all-zero when idle
- start  out  1  one-cycle pulse on the first cycle of an access
- chipselect_en  out  1  high whenever state is not IDLE; gates cs onto the bus
- master_wait  out  NMASTER  per-master wait; low only for the granted master in DONE
- bus_error  out  1  high in DONE when the latched cs is 0

## Operation
- States: IDLE, START, WAIT, DONE.
- IDLE
  - If any req bit is set, pick the winner round-robin: search from (last+1) mod NMASTER upward, wrapping.
  - Load grant one-hot and go to START.
  - No req: stay.
- START
  - start=1. Latch cs into cs_q. Load cnt = table[cs].
  - If req[g] is low: clear grant, go IDLE (abort).
  - Else if table[cs]==0 or cs==0: go DONE.
  - Else go WAIT.
- WAIT
  - If req[g] is low: clear grant, clear cnt, go IDLE.
  - Else if cnt==1: go DONE.
  - Else cnt <= cnt-1.
- DONE
  - master_wait[g]=0. bus_error = (cs_q==0).
  - Stay while req[g] is high.
  - When req[g] drops: clear grant, last <= g, go IDLE.
- Aborted accesses also update last <= g, so an aborting master cannot starve the others.
- Wait-state table
  - 16 entries × DELAYW bits.
  - cfg_we writes table[cfg_cs] <= cfg_delay on the clock edge.
  - The table is read only in START. A write during WAIT or DONE does not change the access in flight.
  - A write to the same index in the same cycle as START: START uses the old value.
- Reset values
  - state=IDLE, grant=0, last=NMASTER-1 (master 0 wins first), cnt=0.
  - Table: all entries 0 except entry 6 (SSRAM) = 2 and entry 5 (LED matrix) = 1.
- Reset outputs: start=0, chipselect_en=0, master_wait=all 1, bus_error=0.
- Reset asserted mid-access returns every output to its reset value on the next edge. No partial completion.

## Timing
- Request sampled high in IDLE at edge k: grant and start visible in cycle k+1 (START).
- Access with D = table[cs]:
  - D ≥ 1: WAIT for D cycles, then DONE. master_wait goes low D+2 cycles after the request is first seen.
  - D = 0 or cs = 0: DONE immediately after START; master_wait goes low 2 cycles after the request is first seen.
- The master must keep req and its address stable from request until it sees master_wait low. It then drops req within any number of cycles.
- After req drops in DONE, IDLE lasts one cycle before the next grant. Minimum turnaround is 3 cycles per access.
- grant never changes except on the IDLE→START, →IDLE transitions. Exactly one grant bit is high in START/WAIT/DONE.
- Requests from non-granted masters are ignored until IDLE; there is no preemption.

## Structure
- Shared package bus_pkg holds:
  - the state enum
  - the NMASTER default and master index constants (CPU=0, VGA=1, DMA=2)
  - chip-select constants (1 vectors, 2 ROM, 3 RAM, 4 IO, 5 LED, 6 SSRAM)
  - reset wait-state values
- Sub-module rr_pick: combinational rotate-priority encoder. Inputs req and last; outputs a one-hot winner and a valid flag. It is instantiated once.
- The table is a flop array, not block RAM, so a write followed by a read in the next cycle is guaranteed.

## Test plan
- Reset table; CPU req with cs=6 → start in cycle 1; master_wait[0] low in cycle 4; held until req drops; grant=000 one cycle after the drop.
- req=111 held, each master dropping req one cycle after its master_wait goes low → grant sequence 001, 010, 100, 001; no master granted twice in a row.
- cfg_we cs=3 delay=5, then VGA req with cs=3 → exactly 5 WAIT cycles, master_wait[1] low in cycle 7.
- DMA req with cs=0 → DONE after START, bus_error=1 only while in DONE, master_wait[2] low in cycle 2.
- CPU drops req in cycle 2 of a cs=6 access → IDLE next cycle, grant=000, master_wait never low. A subsequent VGA-only req is granted.
- Assert reset_n=0 during WAIT → next edge: grant=0, start=0, chipselect_en=0, master_wait=111. Table entry 3 returns to 0.
